// File: rtl/ucsbece154b_fetch_prefetcher_if.sv
// ----------------------------------------------------------------------------
// ucsbece154b_fetch_prefetcher_if
//
// Bundles the two buses of the fetch prefetcher:
//   - instruction-memory read port: mem_req_o / mem_addr_o out, mem_gnt_i /
//     mem_rvalid_i / mem_rdata_i back.
//   - instruction FIFO port: fifo_push_o / fifo_data_o / fifo_flush_o out,
//     fifo_pop_i / fifo_valid_i back.
// Signal names keep the prefetcher's point of view (_o = driven by the
// prefetcher, _i = observed by it).
//
// Modports:
//   master - the prefetcher.
//   slave  - the environment (memory + FIFO side).
// ----------------------------------------------------------------------------
interface ucsbece154b_fetch_prefetcher_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                             mem_req_o;
    logic [ADDR_WIDTH-1:0]            mem_addr_o;
    logic                             mem_gnt_i;
    logic                             mem_rvalid_i;
    logic [DATA_WIDTH-1:0]            mem_rdata_i;

    logic                             fifo_push_o;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_data_o;
    logic                             fifo_pop_i;
    logic                             fifo_valid_i;
    logic                             fifo_flush_o;

    modport master (
        output mem_req_o, mem_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output fifo_push_o, fifo_data_o, fifo_flush_o,
        input  fifo_pop_i, fifo_valid_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  fifo_push_o, fifo_data_o, fifo_flush_o,
        output fifo_pop_i, fifo_valid_i
    );

endinterface

// File: rtl/ucsbece154b_fetch_prefetcher.sv
// ----------------------------------------------------------------------------
// ucsbece154b_fetch_prefetcher
//
// Sequential instruction prefetcher feeding the ucsbece154b_fifo buffer.
// Issues in-order word reads, tags each returned word with its PC and pushes
// it into the FIFO. A credit counter mirrors the free FIFO slots (minus slots
// already reserved by reads in flight) so a push never hits a full FIFO.
// A redirect restarts fetch at a new PC, flushes the FIFO and discards every
// response still owed by memory.
//
// Ports:
//   clk_i          clock, all state on posedge
//   rst_ni         asynchronous active-low reset
//   redirect_i     one-cycle pulse: restart fetch at redirect_pc_i
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   bus            memory read port + FIFO port (master modport)
// ----------------------------------------------------------------------------
module ucsbece154b_fetch_prefetcher #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h0001_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    ucsbece154b_fetch_prefetcher_if.master bus
);

    // One spare bit on both counters so an underflow shows up as an
    // out-of-range value instead of silently wrapping into range.
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1) + 1;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           req_pc_q, req_pc_d;
    logic [ADDR_WIDTH-1:0]           resp_pc_q, resp_pc_d;
    logic [CW-1:0]                   credits_q, credits_d;
    logic [OW-1:0]                   outstanding_q, outstanding_d;
    logic [OW-1:0]                   drop_cnt_q, drop_cnt_d;
    logic                            req_q, req_d;
    logic                            push_q, push_d;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] data_q, data_d;
    logic                            flush_q, flush_d;

    logic grant;
    logic pop_credit;
    logic can_issue;

    // mem_addr_o is the registered request PC itself: it only moves on a
    // grant or a redirect, so it is held stable while a request waits.
    assign bus.mem_req_o    = req_q;
    assign bus.mem_addr_o   = req_pc_q;
    assign bus.fifo_push_o  = push_q;
    assign bus.fifo_data_o  = data_q;
    assign bus.fifo_flush_o = flush_q;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        credits_d     = credits_q;
        drop_cnt_d    = drop_cnt_q;
        req_d         = 1'b0;
        push_d        = 1'b0;
        data_d        = data_q;
        flush_d       = 1'b0;
        can_issue     = 1'b0;

        grant         = req_q & bus.mem_gnt_i;
        // The FIFO is being flushed during REDIRECT, so pops seen there
        // free nothing: credits were already restored to full.
        pop_credit    = bus.fifo_pop_i & bus.fifo_valid_i & (state_q != REDIRECT);
        outstanding_d = outstanding_q + OW'(grant) - OW'(bus.mem_rvalid_i);

        if (redirect_i) begin
            // Every read still owed by memory (including one granted this
            // very cycle) becomes stale; a response arriving now is dropped
            // outright and already removed from outstanding_d.
            state_d    = REDIRECT;
            req_pc_d   = redirect_pc_i & ~ADDR_WIDTH'(3);
            resp_pc_d  = redirect_pc_i & ~ADDR_WIDTH'(3);
            credits_d  = CW'(FIFO_DEPTH);
            drop_cnt_d = outstanding_d;
            flush_d    = 1'b1;
        end else begin
            if (grant) begin
                req_pc_d = req_pc_q + ADDR_WIDTH'(4);
            end
            credits_d = credits_q - CW'(grant) + CW'(pop_credit);

            if (bus.mem_rvalid_i) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - OW'(1);
                end else begin
                    push_d    = 1'b1;
                    data_d    = {resp_pc_q, bus.mem_rdata_i};
                    resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
                end
            end

            // Decided on next-cycle counter values so a back-to-back
            // request can never overrun credits or MAX_OUTSTANDING.
            can_issue = (credits_d != '0) && (outstanding_d < OW'(MAX_OUTSTANDING));
            req_d     = can_issue;

            case (state_q)
                REDIRECT: state_d = FETCH;
                default:  state_d = can_issue ? FETCH : STALL;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the values computed before this edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            credits_q     <= CW'(FIFO_DEPTH);
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            req_q         <= 1'b0;
            push_q        <= 1'b0;
            data_q        <= '0;
            flush_q       <= 1'b0;
        end else begin
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            req_q         <= req_d;
            push_q        <= push_d;
            data_q        <= data_d;
            flush_q       <= flush_d;
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    credits_in_range: assert property (
        @(posedge clk_i) disable iff (!rst_ni) credits_q <= CW'(FIFO_DEPTH)
    );

    outstanding_in_range: assert property (
        @(posedge clk_i) disable iff (!rst_ni) outstanding_q <= OW'(MAX_OUTSTANDING)
    );

endmodule
